// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC / instruction-register fetch stage with jump, call and return
//            redirects. Optional hardware return stack under macro
//            FETCH_CALL_STACK_EN; without it call acts as jump and ret is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [11:0] RESET_PC    = 12'd0,
    parameter int          STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_en,
    input  logic        call_en,
    input  logic        ret_en,
    input  logic [11:0] jump_addr,
    input  logic [18:0] instruction,
    output logic [11:0] address,
    output logic [18:0] ir,
    output logic [11:0] ir_pc,
    output logic        ir_valid,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    logic [11:0] r_pc;
    logic [11:0] r_ir_pc;
    logic [18:0] r_ir;
    logic        r_ir_valid;

    logic        w_redirect;
    logic [11:0] w_target;

`ifdef FETCH_CALL_STACK_EN
    localparam int                c_SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int                c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [c_SP_W-1:0] c_FULL  = c_SP_W'(STACK_DEPTH);
    localparam logic [c_SP_W-1:0] c_ONE   = c_SP_W'(1);

    logic [11:0]       r_stack [STACK_DEPTH];
    logic [c_SP_W-1:0] r_sp;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_call_drop;
    logic              w_ret_drop;
    logic [c_SP_W-1:0] w_sp_m1;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == c_FULL);
    assign w_sp_m1 = r_sp - c_ONE;

    // Only the highest-priority request is considered; if it cannot be
    // honoured it is dropped and lower-priority requests do not step in.
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_call_drop = 1'b0;
        w_ret_drop  = 1'b0;
        w_redirect  = 1'b0;
        w_target    = jump_addr;
        if (ret_en) begin
            if (w_empty) begin
                w_ret_drop = 1'b1;
            end else begin
                w_pop      = 1'b1;
                w_redirect = 1'b1;
                w_target   = r_stack[w_sp_m1[c_IDX_W-1:0]];
            end
        end else if (call_en) begin
            if (w_full) begin
                w_call_drop = 1'b1;
            end else begin
                w_push     = 1'b1;
                w_redirect = 1'b1;
            end
        end else if (jump_en) begin
            w_redirect = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + c_ONE;
            end else if (w_pop) begin
                r_sp <= w_sp_m1;
            end
            if (w_call_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_ret_drop) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Entries above the stack pointer are dead, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp[c_IDX_W-1:0]] <= r_ir_pc + 12'd1;
        end
    end

    assign stack_overflow  = r_overflow;
    assign stack_underflow = r_underflow;
`else
    logic [1:0] w_unused;

    assign w_unused        = {ret_en, (STACK_DEPTH > 1)};
    assign w_redirect      = call_en | jump_en;
    assign w_target        = jump_addr;
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;
`endif

    // A redirect squashes the word currently on the bus and overrides stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= w_target;
            r_ir_valid <= 1'b0;
        end else if (!stall) begin
            r_ir       <= instruction;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + 12'd1;
        end
    end

    assign address  = r_pc;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;

endmodule
`default_nettype wire
